// File: rtl/arb_pkg.sv
// Shared defaults and types for the arbiter request tracker.
package arb_pkg;
    localparam int ARB_NUM_PORTS = 4;

    typedef logic [ARB_NUM_PORTS-1:0] port_vec_t;
endpackage

// File: rtl/arb_request_tracker_if.sv
// Request/grant bundle between the tracker, its clients and the arbiter.
// The master modport is the tracker's side; slave is the environment's side.
interface arb_request_tracker_if
    import arb_pkg::*;
#(
    parameter int NUM_PORTS = ARB_NUM_PORTS,
    parameter int DEPTH     = 7,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) ();
    logic [NUM_PORTS-1:0]       req_pulse_i;
    logic [NUM_PORTS-1:0]       requests_o;
    logic [NUM_PORTS-1:0]       grants_i;
    logic [NUM_PORTS-1:0]       served_o;
    logic [NUM_PORTS*CNT_W-1:0] pending_o;
    logic [NUM_PORTS-1:0]       starve_o;
    logic                       overflow_o;
    logic                       grant_err_o;

    modport master (
        input  req_pulse_i, grants_i,
        output requests_o, served_o, pending_o, starve_o, overflow_o, grant_err_o
    );

    modport slave (
        output req_pulse_i, grants_i,
        input  requests_o, served_o, pending_o, starve_o, overflow_o, grant_err_o
    );
endinterface

// File: rtl/arb_port_slot.sv
// One client's pending counter and starvation timer.
module arb_port_slot #(
    parameter int DEPTH        = 7,
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = $clog2(DEPTH + 1),
    parameter int WAIT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             starve,
    output logic             overflow
);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [WAIT_W-1:0] LIMIT_C = WAIT_W'(STARVE_LIMIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    logic [CNT_W-1:0]  count_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;

    // Next count and wait values; a full port drops the pulse and strobes overflow.
    always_comb begin
        count_nxt = count;
        overflow  = 1'b0;
        if (inc && !dec) begin
            if (count == DEPTH_C) begin
                overflow = 1'b1;
            end else begin
                count_nxt = count + CNT_ONE;
            end
        end else if (dec && !inc) begin
            count_nxt = count - CNT_ONE;
        end

        wait_nxt = wait_cnt;
        if (dec || (count == '0)) begin
            wait_nxt = '0;
        end else if (wait_cnt != LIMIT_C) begin
            wait_nxt = wait_cnt + WAIT_ONE;
        end
    end

    // Counter registers with synchronous, dominant reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            count    <= count_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    assign starve = (wait_cnt == LIMIT_C);
endmodule

// File: rtl/arb_request_tracker.sv
// Requester-side companion to the fixed-priority arbiter: per-port pending
// counters drive the request vector, grants retire them, and illegal grant
// vectors are rejected and flagged.
module arb_request_tracker
    import arb_pkg::*;
#(
    parameter int NUM_PORTS    = ARB_NUM_PORTS,
    parameter int DEPTH        = 7,
    parameter int STARVE_LIMIT = 16,
    parameter int CNT_W        = $clog2(DEPTH + 1),
    parameter int WAIT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input logic                  clk,
    input logic                  reset,
    arb_request_tracker_if.master bus
);
    logic [NUM_PORTS-1:0]       requests;
    logic [NUM_PORTS-1:0]       acc_grant;
    logic [NUM_PORTS-1:0]       ovf_strobe;
    logic [NUM_PORTS-1:0]       starve;
    logic [NUM_PORTS-1:0]       served;
    logic [NUM_PORTS*CNT_W-1:0] pending;
    logic                       grant_legal;
    logic                       overflow;
    logic                       grant_err;

    // Accept a grant only if it is one-hot (or empty) and targets a requesting port.
    always_comb begin
        grant_legal = ((bus.grants_i & (bus.grants_i - NUM_PORTS'(1))) == '0) &&
                      ((bus.grants_i & ~requests) == '0);
        acc_grant   = grant_legal ? bus.grants_i : '0;
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slot
        arb_port_slot #(
            .DEPTH        (DEPTH),
            .STARVE_LIMIT (STARVE_LIMIT),
            .CNT_W        (CNT_W),
            .WAIT_W       (WAIT_W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .inc      (bus.req_pulse_i[i]),
            .dec      (acc_grant[i]),
            .count    (pending[i*CNT_W +: CNT_W]),
            .starve   (starve[i]),
            .overflow (ovf_strobe[i])
        );

        // Requests come from registered counts only, keeping the arbiter loop acyclic.
        assign requests[i] = (pending[i*CNT_W +: CNT_W] != '0);
    end

    // Served register and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            served    <= '0;
            overflow  <= 1'b0;
            grant_err <= 1'b0;
        end else begin
            served <= acc_grant;
            if (|ovf_strobe) begin
                overflow <= 1'b1;
            end
            if (!grant_legal) begin
                grant_err <= 1'b1;
            end
        end
    end

    assign bus.requests_o  = requests;
    assign bus.served_o    = served;
    assign bus.pending_o   = pending;
    assign bus.starve_o    = starve;
    assign bus.overflow_o  = overflow;
    assign bus.grant_err_o = grant_err;
endmodule
